// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus bundle (imem request channel, decode handshake,
// predictor feedback, EX redirect). master = fetch stage, slave = memory/decode/EX side.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] PC_IF;
   logic [31:0] IR_IF;
   logic        jump_pred_IF;
   logic [31:0] jump_addr_IF;
   logic        flush_EX;
   logic [31:0] target_EX;
   logic        exc_IF;

   modport master (
      output imem_req, imem_addr, valid_out, PC_IF, IR_IF, exc_IF,
      input  imem_ack, imem_rdata, ready_in, jump_pred_IF, jump_addr_IF, flush_EX, target_EX
   );

   modport slave (
      input  imem_req, imem_addr, valid_out, PC_IF, IR_IF, exc_IF,
      output imem_ack, imem_rdata, ready_in, jump_pred_IF, jump_addr_IF, flush_EX, target_EX
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the fetch PC; one outstanding imem request, 1 instr/cycle on zero-wait memory.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] LOW_KEEP = 2'b11;
`else
   localparam logic [1:0] LOW_KEEP = 2'b00;
`endif

   typedef enum logic [1:0] {IDLE, REQ, VALID, KILL} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, kill_addr, pc_if, ir_if, next_pc, addr_c;
   logic        valid_q, hs, req_c, mis_fetch, mis_next;

   // Without the trap, low address bits are simply dropped everywhere a PC is captured.
   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], a[1:0] & LOW_KEEP};
   endfunction

   assign hs      = (state == VALID) && bus.ready_in;
   assign next_pc = align(bus.jump_pred_IF ? bus.jump_addr_IF : pc_if + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic exc_q;
   assign mis_fetch = |fetch_pc[1:0];
   assign mis_next  = |next_pc[1:0];
   assign bus.exc_IF = exc_q;

   always_ff @(posedge clk) begin
      if (reset)                          exc_q <= 1'b0;
      else if (bus.flush_EX || hs)        exc_q <= 1'b0;
      else if (state == REQ && mis_fetch) exc_q <= 1'b1;
   end
`else
   assign mis_fetch  = 1'b0;
   assign mis_next   = 1'b0;
   assign bus.exc_IF = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      addr_c    = fetch_pc;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            req_c = !mis_fetch;
            // An issued request cannot be cancelled; a redirect without ack must drain it.
            if (bus.flush_EX)                  state_nxt = (req_c && !bus.imem_ack) ? KILL : REQ;
            else if (mis_fetch || bus.imem_ack) state_nxt = VALID;
         end
         VALID: begin
            addr_c = next_pc;
            if (bus.flush_EX) state_nxt = REQ;
            else if (hs) begin
               req_c     = !mis_next;
               state_nxt = (req_c && bus.imem_ack) ? VALID : REQ;
            end
         end
         KILL: begin
            req_c  = 1'b1;
            addr_c = kill_addr;
            if (bus.imem_ack) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc  <= align(RESET_VEC);
         kill_addr <= align(RESET_VEC);
         pc_if     <= align(RESET_VEC);
         ir_if     <= NOP;
         valid_q   <= 1'b0;
      end else if (bus.flush_EX) begin
         valid_q  <= 1'b0;
         fetch_pc <= align(bus.target_EX);
         if (state == REQ && req_c && !bus.imem_ack) kill_addr <= fetch_pc;
      end else begin
         case (state)
            REQ: if (mis_fetch || bus.imem_ack) begin
               pc_if   <= fetch_pc;
               ir_if   <= mis_fetch ? NOP : bus.imem_rdata;
               valid_q <= 1'b1;
            end
            VALID: if (hs) begin
               fetch_pc <= next_pc;
               if (req_c && bus.imem_ack) begin
                  pc_if <= next_pc;
                  ir_if <= bus.imem_rdata;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req  = req_c;
   assign bus.imem_addr = addr_c;
   assign bus.valid_out = valid_q;
   assign bus.PC_IF     = pc_if;
   assign bus.IR_IF     = ir_if;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random stimulus; a memory model and an architectural
// next-PC model predict every instruction handed to decode.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   fetch_stage_if bus();

   fetch_stage #(.RESET_VEC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0, n_xfer = 0;
   int          mem_cnt = 0, lat_mode = 0;
   bit          mem_busy = 1'b0, stall_prev = 1'b0;
   logic [31:0] exp_pc = 32'h0, mem_addr = 32'h0, held_pc = 32'h0, held_ir = 32'h0;
   logic        s_req, s_valid;
   logic [31:0] s_addr;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] exp_ir(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pc[1:0] != 2'b00) return NOP;
`endif
      return memfn(pc);
   endfunction

   function automatic logic exp_exc(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      return pc[1:0] != 2'b00;
`else
      return 1'b0 & pc[0];
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.ready_in = 1'b0; bus.jump_pred_IF = 1'b0; bus.jump_addr_IF = '0;
      bus.flush_EX = 1'b0; bus.target_EX = '0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      @(posedge clk); #1;
      chk("rst_valid", {31'b0, bus.valid_out}, 32'd0);
      chk("rst_req",   {31'b0, bus.imem_req},  32'd0);
      chk("rst_exc",   {31'b0, bus.exc_IF},    32'd0);
      chk("rst_pc",    bus.PC_IF, 32'h0);
      chk("rst_ir",    bus.IR_IF, NOP);
      reset = 1'b0;
      mem_busy = 1'b0; exp_pc = 32'h0; stall_prev = 1'b0;
   endtask

   // One clock: drive inputs, answer memory, check protocol and the presented instruction.
   task automatic step(input bit rdy, input bit pred, input logic [31:0] ja,
                       input bit fl, input logic [31:0] tg);
      bit ack;
      @(negedge clk);
      s_valid = bus.valid_out;
      if (stall_prev) begin
         chk("stall_valid", {31'b0, bus.valid_out}, 32'd1);
         chk("stall_pc", bus.PC_IF, held_pc);
         chk("stall_ir", bus.IR_IF, held_ir);
      end
      bus.ready_in = rdy; bus.jump_pred_IF = pred; bus.jump_addr_IF = ja;
      bus.flush_EX = fl;  bus.target_EX = tg;      bus.imem_ack = 1'b0;
      #1;
      s_req = bus.imem_req; s_addr = bus.imem_addr;
      if (mem_busy) begin
         chk("req_held", {31'b0, bus.imem_req}, 32'd1);
         chk("addr_stable", bus.imem_addr, mem_addr);
      end else if (bus.imem_req) begin
         mem_busy = 1'b1;
         mem_addr = bus.imem_addr;
         mem_cnt  = (lat_mode > 2) ? int'($urandom_range(2, 0)) : lat_mode;
      end
      if (s_valid && !rdy) chk("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
      if (s_valid && fl)   chk("flush_no_req", {31'b0, bus.imem_req}, 32'd0);
      ack = mem_busy && bus.imem_req && (mem_cnt == 0);
      bus.imem_ack   = ack;
      bus.imem_rdata = ack ? memfn(mem_addr) : $urandom();
      if (fl) exp_pc = tg;
      else if (s_valid && rdy) begin
         chk("pc_if",  bus.PC_IF, exp_pc);
         chk("ir_if",  bus.IR_IF, exp_ir(exp_pc));
         chk("exc_if", {31'b0, bus.exc_IF}, {31'b0, exp_exc(exp_pc)});
         n_xfer++;
         exp_pc = pred ? ja : exp_pc + 32'd4;
      end
      stall_prev = s_valid && !rdy && !fl;
      held_pc = bus.PC_IF; held_ir = bus.IR_IF;
      @(posedge clk);
      if (ack) mem_busy = 1'b0;
      else if (mem_busy && s_req) mem_cnt--;
   endtask

   initial begin
      int k;
      logic [31:0] r;
      // Zero-wait streaming, prediction to 0x40, 3-cycle stall, flush during handshake.
      lat_mode = 0;
      do_reset();
      step(1, 0, 0, 0, 0); chk("idle_no_req", {31'b0, s_req}, 32'd0);
      step(1, 0, 0, 0, 0); chk("first_req", {31'b0, s_req}, 32'd1); chk("first_addr", s_addr, 32'h0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 32'h40, 0, 0); chk("three_xfers", n_xfer, 32'd3);
      repeat (3) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      k = n_xfer;
      step(1, 1, 32'h80, 1, 32'h300); chk("flush_hs_noxfer", n_xfer, k);
      repeat (3) step(1, 0, 0, 0, 0);

      // No prediction at 0x8 falls through to 0xC.
      do_reset();
      repeat (6) step(1, 0, 0, 0, 0);

      // Two-wait memory, redirect while request outstanding -> drain old, refetch 0x100.
      lat_mode = 2;
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h100);
      step(1, 0, 0, 0, 0); chk("kill_old_addr", s_addr, 32'h0); chk("kill_no_valid", {31'b0, s_valid}, 32'd0);
      step(1, 0, 0, 0, 0); chk("kill_new_addr", s_addr, 32'h100); chk("kill_drop", {31'b0, s_valid}, 32'd0);
      repeat (4) step(1, 0, 0, 0, 0);

      // Redirect coincident with ack, then wrap-around at 0xFFFFFFFC.
      lat_mode = 0;
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h200);
      step(1, 0, 0, 0, 0); chk("flush_ack_drop", {31'b0, s_valid}, 32'd0); chk("flush_ack_addr", s_addr, 32'h200);
      step(1, 0, 0, 1, 32'hFFFF_FFFC);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0); chk("wrap_addr", s_addr, 32'h0);
      step(1, 0, 0, 0, 0);

      // Random traffic: random backpressure, predictions, redirects and latencies.
      lat_mode = 3;
      k = n_xfer;
      repeat (3000) begin
         r = $urandom();
         step($urandom_range(9, 0) < 7, $urandom_range(3, 0) == 0, r & 32'hFFFF_FFFC,
              $urandom_range(19, 0) == 0, ($urandom() & 32'hFFFF_FFFC));
      end
      chk("progress", {31'b0, n_xfer > k + 500}, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
      lat_mode = 0;
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h102);
      step(0, 0, 0, 0, 0); chk("trap_no_req", {31'b0, s_req}, 32'd0);
      step(0, 0, 0, 0, 0); #1;
      chk("trap_valid", {31'b0, bus.valid_out}, 32'd1);
      chk("trap_exc",   {31'b0, bus.exc_IF},    32'd1);
      chk("trap_pc",    bus.PC_IF, 32'h102);
      chk("trap_ir",    bus.IR_IF, NOP);
      step(1, 0, 0, 1, 32'h0);
      repeat (3) step(1, 0, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the IF/ID boundary.
- Owns the fetch PC and drives the instruction-memory request interface.
- Presents PC_IF and the fetched word to the gshare predictor and to decode.
- Picks the next PC from the predictor result (jump_pred_IF / jump_addr_IF) or from EX redirects.

Parameters:
- RESET_VEC, 32'h00000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- valid_out  out  1  PC_IF/IR_IF valid to decode
- ready_in  in  1  decode accepts (handshake = valid_out & ready_in)
- PC_IF  out  32  PC of the presented instruction (predictor rPtr/target source)
- IR_IF  out  32  presented instruction
- jump_pred_IF  in  1  predictor: taken (combinational from PC_IF/IR_IF)
- jump_addr_IF  in  32  predictor: target
- flush_EX  in  1  mispredict/redirect from EX
- target_EX  in  32  redirect address
- exc_IF  out  1  misaligned fetch target (only with macro; else tied 0)

Behaviour:
- clk is the only clock. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, fetch_PC=RESET_VEC, PC_IF=RESET_VEC, IR_IF=32'h00000013 (NOP)
  - valid_out=0, imem_req=0, exc_IF=0
- States:
  - IDLE: one cycle after reset release → REQ.
  - REQ: imem_req=1, imem_addr=fetch_PC.
    - On imem_ack: PC_IF<=fetch_PC, IR_IF<=imem_rdata, valid_out<=1 → VALID.
  - VALID: holds PC_IF/IR_IF/valid_out stable while ready_in=0. No request is issued.
    - On handshake: next_PC = jump_pred_IF ? jump_addr_IF : PC_IF+4 (mod 2^32).
    - In the handshake cycle, imem_req=1 and imem_addr=next_PC combinationally.
    - If imem_ack arrives in that cycle: load new PC_IF/IR_IF, stay VALID. This gives 1 instr/cycle with zero-wait memory.
    - Otherwise: fetch_PC<=next_PC, valid_out<=0 → REQ.
  - KILL: imem_req=1 with the old address until imem_ack. rdata is discarded, then → REQ at fetch_PC (already = redirect target).
- Redirect (flush_EX=1) overrides every other event in every state:
  - valid_out<=0, fetch_PC<=target_EX.
  - VALID: the combinational handshake request is suppressed. A handshake in the same cycle does not transfer → REQ.
  - REQ without ack: memory cannot be cancelled → KILL.
  - REQ with ack the same cycle: data discarded → REQ.
  - KILL: stay KILL (or → REQ if ack), target updated.
  - IDLE: fetch_PC<=target_EX, → REQ.
- jump_pred_IF/jump_addr_IF are sampled only in the handshake cycle; ignored otherwise.
- The request protocol is never violated: imem_req never drops, and imem_addr never changes, before ack. The only exception is the combinational VALID-state request, which is not held if ack is absent. It re-issues from REQ next cycle with the same address.
- reset mid-request: the block returns to IDLE. The memory is reset in the same cycle, so no stale ack is expected.
- Only one outstanding request at any time.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - When a selected next_PC or target_EX has [1:0]≠0, no request is issued.
  - The block enters VALID with PC_IF=that address, IR_IF=NOP, exc_IF=1.
  - exc_IF clears on handshake or flush.
- Disabled:
  - exc_IF is tied 0.
  - Address bits [1:0] are forced to 0 on imem_addr and PC_IF.

Test Plan:
- Reset release, RESET_VEC=0, zero-wait memory → imem_addr=0x0 in the cycle after IDLE. PCs 0x0,0x4,0x8 presented on consecutive cycles with ready_in=1.
- jump_pred_IF=1, jump_addr_IF=0x40 at PC_IF=0x8 → next presented PC_IF=0x40. With jump_pred_IF=0 → 0xC.
- ready_in=0 for 3 cycles in VALID → PC_IF/IR_IF/valid_out unchanged, imem_req=0 throughout.
- 2-cycle memory latency, flush_EX=1 target 0x100 one cycle after request → KILL. Old rdata dropped (valid_out stays 0). Next request addr=0x100, presented PC_IF=0x100.
- flush_EX and imem_ack in the same REQ cycle, target 0x200 → rdata discarded, next imem_addr=0x200. Flush during VALID+handshake → no transfer counted.
- PC_IF=0xFFFFFFFC, no prediction → next fetch 0x00000000. With FETCH_MISALIGN_TRAP_EN, target_EX=0x102 → no imem_req, valid_out=1, exc_IF=1, PC_IF=0x102.
